mul_pipe: RTL and testbench

Two-stage pipelined control wrapper around the combinational 64-bit Booth/Wallace multiplier in the EXU. Accepts RV64M multiply ops (MUL, MULH, MULHSU, MULHU, MULW) from the issue side over a valid/ready handshake. Registers the operands, drives the multiplier's sign and word controls, and selects and sign-extends the result. Delivers the result, with its destination tag, to the EXU writeback mux over a second valid/ready handshake.

---
 rtl/mul_pipe_pkg.sv | 42 ++++
 rtl/mul_pipe_mult.sv | 52 +++++
 rtl/mul_pipe.sv | 108 ++++++++++
 tb/tb_mul_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared EXU definitions for the multiply pipeline: opcode encoding, latency and
// the decode from opcode to multiplier controls and result selection.
package mul_pipe_pkg;

  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    SEL_LO = 2'd0,
    SEL_HI = 2'd1,
    SEL_W  = 2'd2
  } res_sel_e;

  typedef struct packed {
    logic     mulw;
    logic     x_sign;
    logic     y_sign;
    res_sel_e sel;
  } mul_ctrl_t;

  localparam int unsigned MUL_LAT = 2;

  // Raw 3-bit opcode in, so reserved encodings fall through to MUL.
  function automatic mul_ctrl_t mul_decode(input logic [2:0] op);
    mul_ctrl_t c;
    c = '{mulw: 1'b0, x_sign: 1'b1, y_sign: 1'b1, sel: SEL_LO};
    case (op)
      MUL_OP_MULH:   c.sel = SEL_HI;
      MUL_OP_MULHSU: begin c.y_sign = 1'b0; c.sel = SEL_HI; end
      MUL_OP_MULHU:  begin c.x_sign = 1'b0; c.y_sign = 1'b0; c.sel = SEL_HI; end
      MUL_OP_MULW:   begin c.mulw = 1'b1; c.sel = SEL_W; end
      default:       c = '{mulw: 1'b0, x_sign: 1'b1, y_sign: 1'b1, sel: SEL_LO};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_pipe_mult.sv
// Combinational 64x64 multiplier with per-operand signedness and a word mode.
// Radix-4 Booth recoding of y; partial products summed modulo 2^128.
import mul_pipe_pkg::*;

module mul_pipe_mult (
  input  logic [63:0]  x,
  input  logic [63:0]  y,
  input  logic         x_sign,
  input  logic         y_sign,
  input  logic         mulw,
  output logic [127:0] prod
);

  logic [63:0]  xa;
  logic [63:0]  ya;
  logic [127:0] xe;
  logic [127:0] xe2;
  logic [66:0]  yz;
  logic [2:0]   trip;
  logic [127:0] pp;
  logic [127:0] acc;
  logic         xs;
  logic         ys;

  always_comb begin
    // Word mode only needs the low 32 product bits, which are independent of
    // operand signedness, so upper operand bits are simply zeroed.
    xa   = mulw ? {32'b0, x[31:0]} : x;
    ya   = mulw ? {32'b0, y[31:0]} : y;
    xs   = x_sign & ~mulw & xa[63];
    ys   = y_sign & ~mulw & ya[63];
    xe   = {{64{xs}}, xa};
    xe2  = xe << 1;
    yz   = {ys, ys, ya, 1'b0};
    trip = '0;
    pp   = '0;
    acc  = '0;
    for (int unsigned i = 0; i < 33; i++) begin
      trip = yz[2*i+2 -: 3];
      case (trip)
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe2;
        3'b100:         pp = -xe2;
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    prod = acc;
  end

endmodule

// File: rtl/mul_pipe.sv
// Two-stage valid/ready wrapper around the EXU multiplier: S1 registers the op,
// S2 registers the selected, sign-extended result and its destination tag.
import mul_pipe_pkg::*;

module mul_pipe #(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [W-1:0]     i_x,
  input  logic [W-1:0]     i_y,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_res,
  output logic [TAG_W-1:0] o_tag
);

  logic             s1_vld;
  logic [2:0]       s1_op;
  logic [W-1:0]     s1_x;
  logic [W-1:0]     s1_y;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_vld;
  logic [W-1:0]     s2_res;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_en;
  logic             s1_adv;
  logic             accept;
  mul_ctrl_t        ctrl;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     res_sel;

  assign s2_en   = ~s2_vld | i_ready;
  assign s1_adv  = s1_vld & s2_en;
  assign o_ready = ~s1_vld | s2_en;
  assign accept  = i_valid & o_ready & ~i_flush;

  assign ctrl = mul_decode(s1_op);

  mul_pipe_mult u_mult (
    .x      (s1_x),
    .y      (s1_y),
    .x_sign (ctrl.x_sign),
    .y_sign (ctrl.y_sign),
    .mulw   (ctrl.mulw),
    .prod   (prod)
  );

  always_comb begin
    res_sel = prod[W-1:0];
    case (ctrl.sel)
      SEL_HI:  res_sel = prod[2*W-1:W];
      SEL_W:   res_sel = {{(W-32){prod[31]}}, prod[31:0]};
      default: res_sel = prod[W-1:0];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1_op  <= '0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_tag <= '0;
    end else begin
      if (i_flush)     s1_vld <= 1'b0;
      else if (accept) s1_vld <= 1'b1;
      else if (s1_adv) s1_vld <= 1'b0;
      if (accept) begin
        s1_op  <= i_op;
        s1_x   <= i_x;
        s1_y   <= i_y;
        s1_tag <= i_tag;
      end
    end
  end

  // A flush still lets a same-cycle output handshake complete; only the valid
  // bit is dropped afterwards, data flops may keep stale contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_vld <= 1'b0;
      s2_res <= '0;
      s2_tag <= '0;
    end else begin
      if (i_flush)      s2_vld <= 1'b0;
      else if (s1_adv)  s2_vld <= 1'b1;
      else if (i_ready) s2_vld <= 1'b0;
      if (s1_adv) begin
        s2_res <= res_sel;
        s2_tag <= s1_tag;
      end
    end
  end

  assign o_valid = s2_vld;
  assign o_res   = s2_res;
  assign o_tag   = s2_tag;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed self-checking bench for mul_pipe: reset, op results, latency,
// throughput, backpressure, flush and mid-stream asynchronous reset.
module tb_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid;
  logic        ready_out;
  logic [2:0]  op;
  logic [63:0] x;
  logic [63:0] y;
  logic [4:0]  tag;
  logic        res_valid;
  logic        ready_in;
  logic [63:0] res;
  logic [4:0]  res_tag;

  int checks   = 0;
  int failures = 0;

  mul_pipe #(.W(64), .TAG_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (valid),
    .o_ready (ready_out),
    .i_op    (op),
    .i_x     (x),
    .i_y     (y),
    .i_tag   (tag),
    .o_valid (res_valid),
    .i_ready (ready_in),
    .o_res   (res),
    .o_tag   (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] t);
    valid = 1'b1; op = o; x = a; y = b; tag = t;
  endtask

  task automatic idle();
    valid = 1'b0; flush = 1'b0; op = '0; x = '0; y = '0; tag = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready_in = 1'b1; idle();
    #12;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", res_valid); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", ready_out); end
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL reset_o_res got=%h exp=0", res); end
    checks++; if (res_tag !== 5'd0) begin failures++; $display("FAIL reset_o_tag got=%0d exp=0", res_tag); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mulhu_latency();
    ready_in = 1'b1;
    drive(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
    tick();
    idle();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mulhu_early_valid got=%b exp=0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL mulhu_valid got=%b exp=1", res_valid); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_res got=%h exp=fffffffffffffffe", res); end
    checks++; if (res_tag !== 5'd5) begin failures++; $display("FAIL mulhu_tag got=%0d exp=5", res_tag); end
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mulhu_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_ops_back_to_back();
    logic [2:0]  vop [8];
    logic [63:0] vx  [8];
    logic [63:0] vy  [8];
    logic [63:0] vex [8];
    vop[0] = 3'd1; vx[0] = 64'hFFFF_FFFF_FFFF_FFFF; vy[0] = 64'hFFFF_FFFF_FFFF_FFFF; vex[0] = 64'h0;
    vop[1] = 3'd0; vx[1] = 64'hFFFF_FFFF_FFFF_FFFF; vy[1] = 64'hFFFF_FFFF_FFFF_FFFF; vex[1] = 64'h1;
    vop[2] = 3'd2; vx[2] = 64'hFFFF_FFFF_FFFF_FFFF; vy[2] = 64'd2; vex[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    vop[3] = 3'd4; vx[3] = 64'h0000_0000_7FFF_FFFF; vy[3] = 64'd2; vex[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    vop[4] = 3'd4; vx[4] = 64'hABCD_0000_7FFF_FFFF; vy[4] = 64'd2; vex[4] = 64'hFFFF_FFFF_FFFF_FFFE;
    vop[5] = 3'd5; vx[5] = 64'd3; vy[5] = 64'd5; vex[5] = 64'd15;
    vop[6] = 3'd3; vx[6] = 64'h8000_0000_0000_0000; vy[6] = 64'd4; vex[6] = 64'd2;
    vop[7] = 3'd1; vx[7] = 64'h8000_0000_0000_0000; vy[7] = 64'd2; vex[7] = 64'hFFFF_FFFF_FFFF_FFFF;
    ready_in = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(vop[k], vx[k], vy[k], 5'(10 + k));
      else idle();
      #1;
      checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL ops_ready k=%0d got=%b exp=1", k, ready_out); end
      tick();
      if (k >= 1) begin
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL ops_valid k=%0d got=%b exp=1", k-1, res_valid); end
        checks++; if (res !== vex[k-1]) begin failures++; $display("FAIL ops_res k=%0d got=%h exp=%h", k-1, res, vex[k-1]); end
        checks++; if (res_tag !== 5'(10 + k - 1)) begin failures++; $display("FAIL ops_tag k=%0d got=%0d exp=%0d", k-1, res_tag, 10+k-1); end
      end
    end
    idle();
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL ops_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    bit stalled_once = 0;
    logic [63:0] held = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (res_valid && !stalled_once) begin stalled_once = 1; stall_left = 3; held = res; end
      ready_in = (stall_left == 0);
      if (sent < 4) drive(3'd0, 64'(sent + 1), 64'd10, 5'(sent + 1));
      else idle();
      #1;
      if (!ready_in) begin
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, ready_out); end
        checks++; if (res !== held) begin failures++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, res, held); end
        stall_left--;
      end
      if (res_valid && ready_in) begin
        checks++; if (res_tag !== 5'(got + 1)) begin failures++; $display("FAIL bp_order got=%0d exp=%0d", res_tag, got+1); end
        checks++; if (res !== 64'(10 * (got + 1))) begin failures++; $display("FAIL bp_res got=%h exp=%h", res, 64'(10*(got+1))); end
        got++;
      end
      if (valid && ready_out) sent++;
      tick();
    end
    idle(); ready_in = 1'b1;
    checks++; if (got !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_dup got=%b exp=0", res_valid); end
  endtask

  task automatic test_flush();
    ready_in = 1'b1;
    drive(3'd0, 64'd3, 64'd3, 5'd7);
    tick();
    drive(3'd0, 64'd4, 64'd4, 5'd8);
    flush = 1'b1;
    tick();
    idle();
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ready_out); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_s1 c=%0d got=%b exp=0", c, res_valid); end
      tick();
    end
    ready_in = 1'b0;
    drive(3'd0, 64'd5, 64'd5, 5'd9);
    tick();
    idle();
    tick();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL flush_fill got=%b exp=1", res_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_s2 got=%b exp=0", res_valid); end
    ready_in = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%b exp=0", res_valid); end
  endtask

  task automatic test_reset_midstream();
    ready_in = 1'b0;
    drive(3'd0, 64'd6, 64'd7, 5'd1);
    tick();
    drive(3'd0, 64'd8, 64'd9, 5'd2);
    tick();
    idle();
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", ready_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", res_valid); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b exp=1", ready_out); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_after c=%0d got=%b exp=0", c, res_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_mulhu_latency();
    test_ops_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
